parallel_accumulator_core: RTL and testbench
============================================

Name: parallel_accumulator_core

Overview:
Single-clock, parametrised successor to the four-processor shared-bus accumulator. A word stack is filled through a load port. NUM_PROC adder lanes then contend round-robin for one shared stack port, popping two words, adding them over ADD_LAT cycles and pushing the sum back, until one word remains. That word is the result. It replaces the separate top/memory/processor/arbiter assembly with one synthesizable block and adds a back-pressured load path, sticky overflow and a deterministic done handshake.

Parameters:
WIDTH, 32, data word width
DEPTH, 1024, stack capacity in words (power of 2 not required, >=2)
NUM_PROC, 4, number of adder lanes (1..16)
ADD_LAT, 2, cycles a lane spends in ADD before requesting push (>=1)

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-low; sampled on posedge clk
load_valid  in  1  load word offered
load_data  in  WIDTH  word to push
load_ready  out  1  high in IDLE when count<DEPTH; load accepted when valid&&ready
start  in  1  begin reduction; honoured only in IDLE
busy  out  1  high in RUN
done  out  1  level; high from reduction end until next accepted load or start
result  out  WIDTH  final sum, valid while done
overflow  out  1  sticky carry-out of any lane add in current reduction
count  out  $clog2(DEPTH+1)  words currently on stack
dbg_grant  out  NUM_PROC  one-hot bus grant this cycle (0 if none)

Behaviour:
- Reset (reset==0 at posedge): top FSM=IDLE, all lanes L_IDLE, count=0, rr pointer=0, load_ready=0 that cycle. busy, done, result, overflow and dbg_grant are all 0. Reset mid-RUN abandons all lane data.
- Top FSM IDLE: accepted load pushes load_data and increments count. Accepted load clears done. start clears done and overflow and enters RUN next cycle. start and load_valid in the same cycle: load accepted first, then start; the loaded word is included.
- IDLE, start with count==0: go to FIN with result=0. count==1: go to FIN with result=top word.
- RUN: load_ready=0, start ignored. Lane FSM: L_IDLE -> (request POP2, granted only if count>=2 at that cycle) L_ADD. L_ADD holds a two-word pair and counts ADD_LAT cycles. Then L_PUSH: request PUSH, and when granted write the sum and return to L_IDLE.
- Shared port: at most one op per cycle. POP2 removes the top two words (count-=2). PUSH adds one word (count+=1).
- Arbitration: round-robin over lanes with an eligible request. Eligible means L_PUSH, or L_IDLE with count>=2. Search starts at pointer; after a grant, pointer = grantee+1 mod NUM_PROC. No grant leaves the pointer unchanged.
- Sum = (a+b) mod 2^WIDTH. A carry out of the MSB sets overflow, which stays set until the next start.
- Termination: count==1 and all lanes L_IDLE -> FIN. FIN (one cycle): result<=top word, count<=0, done<=1, then IDLE.
- Stack never overflows in RUN: every push is preceded by a pop of two.
- Result is independent of NUM_PROC, ADD_LAT and grant order (addition is commutative mod 2^WIDTH).

Decomposition:
- Package acc_pkg: top state enum (IDLE, RUN, FIN), lane state enum (L_IDLE, L_ADD, L_PUSH), bus op enum (OP_NONE, OP_POP2, OP_PUSH).
- Sub-module acc_rr_arbiter (parameter N): req[N] -> one-hot grant[N], with an internal pointer using the same sync active-low reset.
- Lanes and the stack RAM (dual-read top/top-1, single write) stay in the core.

Test Plan:
- Defaults. Load 1,2,3,4, then start. Expect: busy during RUN; done=1 with result=10, overflow=0, count=0; dbg_grant always one-hot or 0.
- WIDTH=32. Load 0xFFFFFFFF and 0x2, then start. Expect result=0x00000001 and overflow=1. Then load 5 and start. Expect overflow cleared and result=5.
- DEPTH=8. Drive load_valid for 9 cycles. Expect 8 accepted, load_ready=0 on the 9th, count=8. Start with words 1..8. Expect result=36.
- NUM_PROC=2, load 16 words of 1, then start. Expect dbg_grant never grants the same lane twice in a row when both are eligible, and result=16.
- Start with count=0 -> result=0 and done in 2 cycles. Start with count=1 (value 7) -> result=7.
- Load 1..8, start, and assert reset=0 for one cycle mid-RUN. Expect all outputs 0 and count=0 next cycle. Reload 1..4 and start. Expect result=10.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared state and bus-operation encodings for the parallel accumulator core.
package acc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} topState_e;

  typedef enum logic [1:0] {L_IDLE, L_ADD, L_PUSH} laneState_e;

  typedef enum logic [1:0] {OP_NONE, OP_POP2, OP_PUSH} busOp_e;

endpackage

// File: rtl/acc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer, pointer
// moves past the grantee only when something is granted.
module acc_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_d        = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/parallel_accumulator_core.sv
// Word stack reduced to a single sum by NUM_PROC adder lanes sharing one
// stack port (pop two / push one per cycle) under round-robin arbitration.
module parallel_accumulator_core
  import acc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 1024,
  parameter int NUM_PROC = 4,
  parameter int ADD_LAT  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  output logic                       load_ready,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [NUM_PROC-1:0]        dbg_grant
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int GW   = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int CNTW = $clog2(ADD_LAT + 1);
  localparam logic [CW-1:0]   ONE_C   = CW'(1);
  localparam logic [CW-1:0]   TWO_C   = CW'(2);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CNTW-1:0] LAST_C  = CNTW'(ADD_LAT - 1);

  topState_e        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] result_q, result_d;

  laneState_e       laneState_q [NUM_PROC];
  logic [CNTW-1:0]  laneCnt_q   [NUM_PROC];
  logic [WIDTH-1:0] laneA_q     [NUM_PROC];
  logic [WIDTH-1:0] laneB_q     [NUM_PROC];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] topWord, nextWord;
  logic             memWe;
  logic [AW-1:0]    memWAddr;
  logic [WIDTH-1:0] memWData;

  logic [NUM_PROC-1:0] req, grant;
  logic [GW-1:0]       grantIdx;
  logic                allIdle;
  busOp_e              busOp;
  logic [WIDTH:0]      pushSum;
  logic                loadFire;

  assign topWord  = mem[AW'(count_q - ONE_C)];
  assign nextWord = mem[AW'(count_q - TWO_C)];

  assign load_ready = reset && (state_q == IDLE) && (count_q < DEPTH_C);
  assign loadFire   = load_valid && load_ready;

  acc_rr_arbiter #(.N(NUM_PROC)) uArb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req),
    .grant_o (grant)
  );

  // Idle lanes may only ask for a pop when a full pair is on the stack.
  always_comb begin
    req      = '0;
    allIdle  = 1'b1;
    grantIdx = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (laneState_q[i] != L_IDLE) allIdle = 1'b0;
      if (state_q == RUN && (laneState_q[i] == L_PUSH ||
          (laneState_q[i] == L_IDLE && count_q >= TWO_C))) req[i] = 1'b1;
      if (grant[i]) grantIdx = GW'(i);
    end
    busOp = OP_NONE;
    if (grant != '0) busOp = (laneState_q[grantIdx] == L_PUSH) ? OP_PUSH : OP_POP2;
  end

  assign pushSum = {1'b0, laneA_q[grantIdx]} + {1'b0, laneB_q[grantIdx]};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    result_d   = result_q;
    memWe      = 1'b0;
    memWAddr   = AW'(count_q);
    memWData   = load_data;
    case (state_q)
      IDLE: begin
        if (loadFire) begin
          memWe   = 1'b1;
          count_d = count_q + ONE_C;
          done_d  = 1'b0;
        end
        // Fewer than two words needs no lanes; go straight to the result.
        if (start) begin
          done_d     = 1'b0;
          overflow_d = 1'b0;
          state_d    = (count_d < TWO_C) ? FIN : RUN;
        end
      end
      RUN: begin
        case (busOp)
          OP_POP2: count_d = count_q - TWO_C;
          OP_PUSH: begin
            memWe    = 1'b1;
            memWData = pushSum[WIDTH-1:0];
            count_d  = count_q + ONE_C;
            if (pushSum[WIDTH]) overflow_d = 1'b1;
          end
          default: ;
        endcase
        if (busOp == OP_NONE && allIdle && count_q <= ONE_C) state_d = FIN;
      end
      FIN: begin
        result_d = (count_q == '0) ? '0 : topWord;
        count_d  = '0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      result_q   <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && memWe) mem[memWAddr] <= memWData;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PROC; i++) begin
      if (!reset) begin
        laneState_q[i] <= L_IDLE;
        laneCnt_q[i]   <= '0;
        laneA_q[i]     <= '0;
        laneB_q[i]     <= '0;
      end else begin
        case (laneState_q[i])
          L_IDLE: if (grant[i]) begin
            laneA_q[i]     <= topWord;
            laneB_q[i]     <= nextWord;
            laneCnt_q[i]   <= '0;
            laneState_q[i] <= L_ADD;
          end
          L_ADD: begin
            if (laneCnt_q[i] == LAST_C) laneState_q[i] <= L_PUSH;
            else laneCnt_q[i] <= laneCnt_q[i] + 1'b1;
          end
          L_PUSH: if (grant[i]) laneState_q[i] <= L_IDLE;
          default: laneState_q[i] <= L_IDLE;
        endcase
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign count     = count_q;
  assign dbg_grant = grant;

endmodule

// File: tb/tb_parallel_accumulator_core.sv
// Directed bench for parallel_accumulator_core: sums, overflow, full stack,
// trivial reductions, load+start ordering and reset during a reduction.
module tb_parallel_accumulator_core;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 16;
  localparam int NUM_PROC = 3;
  localparam int ADD_LAT  = 2;
  localparam int CW       = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                load_valid = 1'b0;
  logic [WIDTH-1:0]    load_data = '0;
  logic                load_ready;
  logic                start = 1'b0;
  logic                busy, done, overflow;
  logic [WIDTH-1:0]    result;
  logic [CW-1:0]       count;
  logic [NUM_PROC-1:0] dbg_grant;

  int compared = 0;
  int mismatched = 0;

  parallel_accumulator_core #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_PROC(NUM_PROC), .ADD_LAT(ADD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .busy(busy), .done(done),
    .result(result), .overflow(overflow), .count(count), .dbg_grant(dbg_grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [WIDTH-1:0] v, output bit accepted);
    load_valid = 1'b1;
    load_data  = v;
    accepted   = load_ready;
    tick();
    load_valid = 1'b0;
  endtask

  // Pulses start (optionally with a same-cycle load) and observes until done.
  task automatic runReduction(input bit withLoad, input logic [WIDTH-1:0] extra,
                              output int cycles, output int grants, output int badGrants,
                              output logic [NUM_PROC-1:0] firstG, output logic [NUM_PROC-1:0] secondG,
                              output bit sawBusy, output bit timedOut);
    load_valid = withLoad;
    load_data  = extra;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    load_valid = 1'b0;
    cycles = 1; grants = 0; badGrants = 0; firstG = '0; secondG = '0; sawBusy = 1'b0;
    while (!done && cycles < 400) begin
      if (busy) sawBusy = 1'b1;
      if (!$onehot0(dbg_grant)) badGrants++;
      if (dbg_grant != '0) begin
        if (grants == 0) firstG = dbg_grant;
        else if (grants == 1) secondG = dbg_grant;
        grants++;
      end
      tick();
      cycles++;
    end
    timedOut = !done;
  endtask

  task automatic test_reset();
    reset = 1'b0; load_valid = 1'b0; start = 1'b0;
    tick();
    compared++; if (load_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready_low: got %b want 0", load_ready); end
    compared++; if ({busy, done, overflow} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b want 000", {busy, done, overflow}); end
    compared++; if (result !== '0) begin mismatched++; $display("[TB] FAIL reset_result: got %0h want 0", result); end
    compared++; if (count !== '0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    compared++; if (dbg_grant !== '0) begin mismatched++; $display("[TB] FAIL reset_grant: got %b want 0", dbg_grant); end
    reset = 1'b1;
    #1;
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready_high: got %b want 1", load_ready); end
  endtask

  task automatic test_basic_sum();
    bit acc; int cyc, gr, bad; logic [NUM_PROC-1:0] g1, g2; bit sb, to;
    for (int i = 1; i <= 4; i++) loadWord(WIDTH'(i), acc);
    compared++; if (count !== CW'(4)) begin mismatched++; $display("[TB] FAIL basic_count_loaded: got %0d want 4", count); end
    runReduction(1'b0, '0, cyc, gr, bad, g1, g2, sb, to);
    compared++; if (to) begin mismatched++; $display("[TB] FAIL basic_timeout: got done=%b want 1", done); end
    compared++; if (!sb) begin mismatched++; $display("[TB] FAIL basic_busy: got busy never seen want busy in RUN"); end
    compared++; if (result !== 32'd10) begin mismatched++; $display("[TB] FAIL basic_result: got %0d want 10", result); end
    compared++; if ({overflow, busy} !== 2'b00) begin mismatched++; $display("[TB] FAIL basic_flags: got ovf,busy=%b want 00", {overflow, busy}); end
    compared++; if (count !== '0) begin mismatched++; $display("[TB] FAIL basic_count_end: got %0d want 0", count); end
    compared++; if (gr !== 6) begin mismatched++; $display("[TB] FAIL basic_grants: got %0d want 6", gr); end
    compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL basic_onehot: got %0d bad grants want 0", bad); end
    compared++; if ({g1, g2} !== {3'b001, 3'b010}) begin mismatched++; $display("[TB] FAIL basic_rr_order: got %b,%b want 001,010", g1, g2); end
  endtask

  task automatic test_overflow();
    bit acc; int cyc, gr, bad; logic [NUM_PROC-1:0] g1, g2; bit sb, to;
    loadWord(32'hFFFF_FFFF, acc);
    loadWord(32'h0000_0002, acc);
    runReduction(1'b0, '0, cyc, gr, bad, g1, g2, sb, to);
    compared++; if (result !== 32'h0000_0001) begin mismatched++; $display("[TB] FAIL ovf_result: got %0h want 1", result); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_set: got %b want 1", overflow); end
    loadWord(32'd5, acc);
    compared++; if ({done, overflow} !== 2'b01) begin mismatched++; $display("[TB] FAIL ovf_after_load: got done,ovf=%b want 01", {done, overflow}); end
    runReduction(1'b0, '0, cyc, gr, bad, g1, g2, sb, to);
    compared++; if ({result, overflow} !== {32'd5, 1'b0}) begin mismatched++; $display("[TB] FAIL ovf_cleared: got result=%0d ovf=%b want 5,0", result, overflow); end
  endtask

  task automatic test_full_stack();
    bit acc; int accepted; bit lastReady; int cyc, gr, bad; logic [NUM_PROC-1:0] g1, g2; bit sb, to;
    accepted = 0; lastReady = 1'b1;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      loadWord(WIDTH'(i), acc);
      if (acc) accepted++;
      if (i == DEPTH + 1) lastReady = acc;
    end
    compared++; if (accepted !== DEPTH) begin mismatched++; $display("[TB] FAIL full_accepted: got %0d want %0d", accepted, DEPTH); end
    compared++; if (lastReady !== 1'b0) begin mismatched++; $display("[TB] FAIL full_ready: got %b want 0", lastReady); end
    compared++; if (count !== CW'(DEPTH)) begin mismatched++; $display("[TB] FAIL full_count: got %0d want %0d", count, DEPTH); end
    runReduction(1'b0, '0, cyc, gr, bad, g1, g2, sb, to);
    compared++; if (to || result !== 32'd136) begin mismatched++; $display("[TB] FAIL full_result: got %0d (timeout=%b) want 136", result, to); end
    compared++; if (gr !== 30 || bad !== 0) begin mismatched++; $display("[TB] FAIL full_grants: got %0d grants %0d bad want 30,0", gr, bad); end
  endtask

  task automatic test_empty_and_single();
    bit acc; int cyc, gr, bad; logic [NUM_PROC-1:0] g1, g2; bit sb, to;
    runReduction(1'b0, '0, cyc, gr, bad, g1, g2, sb, to);
    compared++; if (cyc !== 2 || done !== 1'b1) begin mismatched++; $display("[TB] FAIL empty_latency: got %0d cycles done=%b want 2,1", cyc, done); end
    compared++; if (result !== '0) begin mismatched++; $display("[TB] FAIL empty_result: got %0d want 0", result); end
    loadWord(32'd7, acc);
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL single_done_clear: got %b want 0", done); end
    runReduction(1'b0, '0, cyc, gr, bad, g1, g2, sb, to);
    compared++; if (to || result !== 32'd7) begin mismatched++; $display("[TB] FAIL single_result: got %0d want 7", result); end
  endtask

  task automatic test_start_with_load();
    bit acc; int cyc, gr, bad; logic [NUM_PROC-1:0] g1, g2; bit sb, to;
    loadWord(32'd4, acc);
    loadWord(32'd5, acc);
    runReduction(1'b1, 32'd6, cyc, gr, bad, g1, g2, sb, to);
    compared++; if (to || result !== 32'd15) begin mismatched++; $display("[TB] FAIL startload_result: got %0d want 15", result); end
    compared++; if (gr !== 4) begin mismatched++; $display("[TB] FAIL startload_grants: got %0d want 4", gr); end
  endtask

  task automatic test_midrun_reset();
    bit acc; int cyc, gr, bad; logic [NUM_PROC-1:0] g1, g2; bit sb, to;
    for (int i = 1; i <= 8; i++) loadWord(WIDTH'(i), acc);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL midrun_busy: got %b want 1", busy); end
    reset = 1'b0;
    tick();
    compared++; if ({busy, done, overflow, result, count, dbg_grant} !== '0) begin mismatched++;
      $display("[TB] FAIL midrun_reset_outputs: got busy=%b done=%b ovf=%b res=%0h cnt=%0d grant=%b want all 0", busy, done, overflow, result, count, dbg_grant); end
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) loadWord(WIDTH'(i), acc);
    runReduction(1'b0, '0, cyc, gr, bad, g1, g2, sb, to);
    compared++; if (to || result !== 32'd10) begin mismatched++; $display("[TB] FAIL midrun_reload_result: got %0d want 10", result); end
    compared++; if (g1 !== 3'b001) begin mismatched++; $display("[TB] FAIL midrun_ptr_reset: got %b want 001", g1); end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_overflow();
    test_full_stack();
    test_empty_and_single();
    test_start_with_load();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
